// File: rtl/cfg_frame_tx.sv
// cfg_frame_tx
//
// Readback transmitter for the camera-edge configuration channel. A request
// snapshots the live configuration values and streams them out as
// address/data byte pairs in the same framing the configuration decoder
// accepts: 0x01 status, 0x02 gray threshold, 0x03 radius.
//
// Optional feature macro: CFG_TX_CHECKSUM_EN
//   defined   : a seventh byte (8-bit sum of the six preceding bytes) closes
//               the frame
//   undefined : the frame is exactly six bytes
//
// Parameters
//   BYTE_GAP    idle cycles (dout_vld low) after each accepted byte, 0..255
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   send_req    one-cycle frame request, honoured only while idle
//   cfg_flag    configuration-enable sequence completed (level)
//   gray_value  current gray threshold
//   radius      current radius
//   tx_rdy      downstream transmitter can take a byte this cycle
//   dout        byte to transmit
//   dout_vld    dout valid; a byte moves on an edge with dout_vld && tx_rdy
//   busy        frame in progress
//   done        one-cycle pulse after the last byte of a frame is accepted
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no frame; waiting for send_req
// ADDR   | address byte (reg_idx+1) presented, or pending behind a gap
// DATA   | data byte for reg_idx presented, or pending behind a gap
// SUM    | checksum byte presented, or pending behind a gap (macro only)
//
// The gap counter overlays ADDR/DATA/SUM: while it is non-zero dout_vld is
// low and the state names the byte that will be presented when it expires.

module cfg_frame_tx #(
    parameter int unsigned BYTE_GAP = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_req,
    input  logic       cfg_flag,
    input  logic [7:0] gray_value,
    input  logic [7:0] radius,
    input  logic       tx_rdy,
    output logic [7:0] dout,
    output logic       dout_vld,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] GAP_LOAD = 8'(BYTE_GAP);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
`ifdef CFG_TX_CHECKSUM_EN
        ,
        S_SUM  = 2'd3
`endif
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] reg_idx, reg_idx_nxt;
    logic [7:0] gap_cnt, gap_cnt_nxt;
    logic       snap_flag, snap_flag_nxt;
    logic [7:0] snap_gray, snap_gray_nxt;
    logic [7:0] snap_radius, snap_radius_nxt;
    logic [7:0] dout_nxt;
    logic       dout_vld_nxt;
    logic       busy_nxt;
    logic       done_nxt;

`ifdef CFG_TX_CHECKSUM_EN
    logic [7:0] sum_acc, sum_acc_nxt;
    logic [7:0] sum_add;
`endif

    // Where the frame goes after the byte currently presented is accepted.
    state_t     st_after;
    logic [1:0] idx_after;
    logic       last_byte;

    // Byte contents for a given position in the frame, from the snapshot.
    logic [7:0] byte_after;
    logic [7:0] byte_cur;

    logic       xfer;

    function automatic logic [7:0] byte_sel(input state_t st, input logic [1:0] idx,
                                            input logic fl, input logic [7:0] gr,
                                            input logic [7:0] ra);
        logic [7:0] b;
        b = 8'h00;
        case (st)
            S_ADDR: b = {6'b0, idx} + 8'd1;
            S_DATA: begin
                case (idx)
                    2'd0:    b = {7'b0, fl};
                    2'd1:    b = gr;
                    default: b = ra;
                endcase
            end
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign xfer = dout_vld & tx_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            reg_idx     <= 2'd0;
            gap_cnt     <= 8'd0;
            snap_flag   <= 1'b0;
            snap_gray   <= 8'h00;
            snap_radius <= 8'h00;
            dout        <= 8'h00;
            dout_vld    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef CFG_TX_CHECKSUM_EN
            sum_acc     <= 8'h00;
`endif
        end else begin
            state       <= state_nxt;
            reg_idx     <= reg_idx_nxt;
            gap_cnt     <= gap_cnt_nxt;
            snap_flag   <= snap_flag_nxt;
            snap_gray   <= snap_gray_nxt;
            snap_radius <= snap_radius_nxt;
            dout        <= dout_nxt;
            dout_vld    <= dout_vld_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
`ifdef CFG_TX_CHECKSUM_EN
            sum_acc     <= sum_acc_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt       = state;
        reg_idx_nxt     = reg_idx;
        gap_cnt_nxt     = gap_cnt;
        snap_flag_nxt   = snap_flag;
        snap_gray_nxt   = snap_gray;
        snap_radius_nxt = snap_radius;
        dout_nxt        = dout;
        dout_vld_nxt    = dout_vld;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        st_after        = state;
        idx_after       = reg_idx;
        last_byte       = 1'b0;
`ifdef CFG_TX_CHECKSUM_EN
        sum_acc_nxt     = sum_acc;
        sum_add         = sum_acc + dout;
`endif

        case (state)
            S_ADDR: st_after = S_DATA;
            S_DATA: begin
                if (reg_idx != 2'd2) begin
                    st_after  = S_ADDR;
                    idx_after = reg_idx + 2'd1;
                end else begin
`ifdef CFG_TX_CHECKSUM_EN
                    st_after  = S_SUM;
`else
                    last_byte = 1'b1;
`endif
                end
            end
`ifdef CFG_TX_CHECKSUM_EN
            S_SUM:  last_byte = 1'b1;
`endif
            default: st_after = state;
        endcase

        byte_after = byte_sel(st_after, idx_after, snap_flag, snap_gray, snap_radius);
        byte_cur   = byte_sel(state, reg_idx, snap_flag, snap_gray, snap_radius);
`ifdef CFG_TX_CHECKSUM_EN
        // With no gap the checksum is presented on the same edge that adds
        // the last data byte, so it has to come from the adder, not the reg.
        if (st_after == S_SUM) byte_after = sum_add;
        if (state == S_SUM)    byte_cur   = sum_acc;
`endif

        if (state == S_IDLE) begin
            if (send_req) begin
                snap_flag_nxt   = cfg_flag;
                snap_gray_nxt   = gray_value;
                snap_radius_nxt = radius;
                state_nxt       = S_ADDR;
                reg_idx_nxt     = 2'd0;
                gap_cnt_nxt     = 8'd0;
                dout_nxt        = 8'h01;
                dout_vld_nxt    = 1'b1;
                busy_nxt        = 1'b1;
`ifdef CFG_TX_CHECKSUM_EN
                sum_acc_nxt     = 8'h00;
`endif
            end
        end else if (xfer) begin
`ifdef CFG_TX_CHECKSUM_EN
            sum_acc_nxt = sum_add;
`endif
            if (last_byte) begin
                state_nxt    = S_IDLE;
                reg_idx_nxt  = 2'd0;
                gap_cnt_nxt  = 8'd0;
                dout_nxt     = 8'h00;
                dout_vld_nxt = 1'b0;
                busy_nxt     = 1'b0;
                done_nxt     = 1'b1;
            end else begin
                state_nxt   = st_after;
                reg_idx_nxt = idx_after;
                if (BYTE_GAP == 0) begin
                    dout_vld_nxt = 1'b1;
                    dout_nxt     = byte_after;
                end else begin
                    dout_vld_nxt = 1'b0;
                    gap_cnt_nxt  = GAP_LOAD;
                end
            end
        end else if (gap_cnt != 8'd0) begin
            // Down-counting gap; the pending byte goes valid as it expires.
            gap_cnt_nxt = gap_cnt - 8'd1;
            if (gap_cnt == 8'd1) begin
                dout_vld_nxt = 1'b1;
                dout_nxt     = byte_cur;
            end
        end
    end

endmodule

// File: tb/tb_cfg_frame_tx.sv
// Bench for cfg_frame_tx: two instances (BYTE_GAP=0 and BYTE_GAP=3) share
// stimulus; a queue-based frame model predicts every output each cycle, and
// directed sections pin the model with literal expectations.
module tb_cfg_frame_tx;

`ifdef CFG_TX_CHECKSUM_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    typedef logic [7:0] frame_t [7];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       send_req = 1'b0;
    logic       cfg_flag = 1'b0;
    logic [7:0] gray_value = 8'h00;
    logic [7:0] radius = 8'h00;
    logic       tx_rdy = 1'b0;

    logic [7:0] dout0, dout3;
    logic       vld0, vld3, busy0, busy3, done0, done3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cfg_frame_tx #(.BYTE_GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .send_req(send_req), .cfg_flag(cfg_flag),
        .gray_value(gray_value), .radius(radius), .tx_rdy(tx_rdy),
        .dout(dout0), .dout_vld(vld0), .busy(busy0), .done(done0)
    );

    cfg_frame_tx #(.BYTE_GAP(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .send_req(send_req), .cfg_flag(cfg_flag),
        .gray_value(gray_value), .radius(radius), .tx_rdy(tx_rdy),
        .dout(dout3), .dout_vld(vld3), .busy(busy3), .done(done3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic frame_t build_frame(input logic f, input logic [7:0] g,
                                           input logic [7:0] r);
        frame_t fr;
        fr[0] = 8'h01; fr[1] = {7'b0, f};
        fr[2] = 8'h02; fr[3] = g;
        fr[4] = 8'h03; fr[5] = r;
        fr[6] = fr[0] + fr[1] + fr[2] + fr[3] + fr[4] + fr[5];
        return fr;
    endfunction

    function automatic int gap_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    // ---------------- behavioural model: frame as a byte queue -------------
    bit         mb [2];
    bit         mv [2];
    bit         md [2];
    int         mg [2];
    logic [7:0] mq [2][$];

    always @(posedge clk or negedge rst_n) begin
        frame_t fr;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mb[i] = 0; mv[i] = 0; md[i] = 0; mg[i] = 0;
                mq[i].delete();
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                md[i] = 0;
                if (!mb[i]) begin
                    if (send_req) begin
                        fr = build_frame(cfg_flag, gray_value, radius);
                        for (int k = 0; k < NB; k++) mq[i].push_back(fr[k]);
                        mb[i] = 1; mv[i] = 1; mg[i] = 0;
                    end
                end else if (mv[i]) begin
                    if (tx_rdy) begin
                        void'(mq[i].pop_front());
                        if (mq[i].size() == 0) begin
                            mb[i] = 0; mv[i] = 0; md[i] = 1;
                        end else if (gap_of(i) == 0) begin
                            mv[i] = 1;
                        end else begin
                            mv[i] = 0; mg[i] = gap_of(i);
                        end
                    end
                end else begin
                    mg[i]--;
                    if (mg[i] == 0) mv[i] = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ------------------------------------
    always @(negedge clk) begin
        logic [7:0] d;
        logic       v, b, dn;
        logic [7:0] ed;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                d  = (i == 0) ? dout0 : dout3;
                v  = (i == 0) ? vld0  : vld3;
                b  = (i == 0) ? busy0 : busy3;
                dn = (i == 0) ? done0 : done3;
                ed = (mv[i] && mq[i].size() > 0) ? mq[i][0] : 8'h00;
                chk((i == 0) ? "cycle_gap0" : "cycle_gap3",
                    {21'd0, b, v, dn, (v ? d : 8'h00)},
                    {21'd0, mb[i], mv[i], md[i], ed});
            end
        end
    end

    // ---------------- monitors ---------------------------------------------
    int         cyc = 0;
    logic [7:0] got0 [$];
    logic [7:0] got3 [$];
    int         t3 [$];
    int         nd0 = 0;
    int         nd3 = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            cyc++;
            if (vld0 && tx_rdy) got0.push_back(dout0);
            if (vld3 && tx_rdy) begin
                got3.push_back(dout3);
                t3.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (done0) nd0++;
        if (done3) nd3++;
    end

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy0 && !busy3 && !done0 && !done3) begin
                ok = 1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL idle_timeout actual=busy required=idle at %0t", $time);
        end
    endtask

    task automatic start_frame(input logic f, input logic [7:0] g, input logic [7:0] r);
        cfg_flag   = f;
        gray_value = g;
        radius     = r;
        send_req   = 1'b1;
        @(negedge clk);
        send_req   = 1'b0;
    endtask

    // ---------------- directed + random stimulus ---------------------------
    initial begin
        frame_t ef;
        int     nb;
        bit     seen;

        repeat (2) @(negedge clk);
        chk("reset_outputs", {dout0, vld0, busy0, done0, dout3, vld3, busy3, done3}, 32'h0);
        rst_n = 1'b1;
        tx_rdy = 1'b1;
        @(negedge clk);

        // Basic frame with literal bytes
        got0.delete();
        ef[0] = 8'h01; ef[1] = 8'h01; ef[2] = 8'h02; ef[3] = 8'h80;
        ef[4] = 8'h03; ef[5] = 8'h05; ef[6] = 8'h8C;
        start_frame(1'b1, 8'h80, 8'h05);
        for (int k = 0; k < NB; k++) begin
            chk("basic_byte", {vld0, dout0}, {1'b1, ef[k]});
            @(negedge clk);
        end
        chk("basic_done", {done0, busy0, vld0}, 3'b100);
        wait_idle();
        chk("basic_count", got0.size(), NB);

        // Backpressure on the 0x02 byte
        got0.delete();
        start_frame(1'b0, 8'h33, 8'h44);
        @(negedge clk);
        @(negedge clk);
        tx_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold", {vld0, dout0}, {1'b1, 8'h02});
            @(negedge clk);
        end
        tx_rdy = 1'b1;
        wait_idle();
        ef = build_frame(1'b0, 8'h33, 8'h44);
        chk("bp_count", got0.size(), NB);
        for (int k = 0; k < NB && k < got0.size(); k++) chk("bp_frame", got0[k], ef[k]);

        // Snapshot: gray changes after acceptance
        got0.delete();
        start_frame(1'b1, 8'h80, 8'h05);
        gray_value = 8'h10;
        wait_idle();
        chk("snap_count", got0.size(), NB);
        if (got0.size() > 3) chk("snap_gray", got0[3], 8'h80);

        // Gap instance: ignored mid-frame request, spacing, restart in done cycle
        got3.delete();
        t3.delete();
        nb = nd3;
        start_frame(1'b0, 8'h5A, 8'hA5);
        repeat (6) @(negedge clk);
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            if (done3) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("gap_done_seen", seen, 1'b1);
        send_req = 1'b1;
        @(negedge clk);
        send_req = 1'b0;
        chk("gap_restart", {vld3, busy3, dout3}, {1'b1, 1'b1, 8'h01});
        chk("gap_one_frame", nd3 - nb, 1);
        chk("gap_count", got3.size(), NB);
        ef = build_frame(1'b0, 8'h5A, 8'hA5);
        for (int k = 0; k < NB && k < got3.size(); k++) chk("gap_frame", got3[k], ef[k]);
        for (int k = 1; k < t3.size(); k++) chk("gap_spacing", t3[k] - t3[k-1], 4);
        wait_idle();

        // Reset mid-frame after the third byte
        nb = nd0;
        start_frame(1'b1, 8'h77, 8'h66);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("abort_outputs", {dout0, vld0, busy0, done0, dout3, vld3, busy3, done3}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_done", nd0 - nb, 0);
        start_frame(1'b0, 8'h12, 8'h34);
        chk("abort_restart", {vld0, dout0}, {1'b1, 8'h01});
        wait_idle();

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            send_req   = ($urandom_range(0, 7) == 0);
            tx_rdy     = ($urandom_range(0, 3) != 0);
            cfg_flag   = 1'($urandom);
            gray_value = 8'($urandom);
            radius     = 8'($urandom);
        end
        send_req = 1'b0;
        tx_rdy   = 1'b1;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
